// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_t;

  // Force a branch/jump target onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture/hold register for an instruction returned while the pipeline is stalled.
module fetch_hold_buf
  import mips_pkg::*;
#(
  parameter int unsigned W = INST_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a redirect always drops the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/valid handshake,
// holds a returned word across stalls and discards wrong-path responses.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   nextaddress,
  output logic              ifid_ld,
  output logic              flush
);

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt, pc_inc;
  logic [PC_W-1:0]   kill_addr, kill_nxt;
  logic [INST_W-1:0] hold_inst;
  logic              hold_ld, hold_clr;
  logic              req_c, ld_c, flush_c;
  logic [PC_W-1:0]   addr_c, next_c;
  logic [INST_W-1:0] inst_c;

  assign pc_inc = pc + PC_W'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      kill_addr <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      kill_addr <= kill_nxt;
    end
  end

  fetch_hold_buf #(.W(INST_W)) u_hold_buf (
    .clk (clk),
    .rst (rst),
    .ld  (hold_ld),
    .clr (hold_clr),
    .d   (imem_rdata),
    .q   (hold_inst)
  );

  // Redirect takes the PC in every state and overrides pc_stall.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill_addr;
    hold_ld   = 1'b0;
    hold_clr  = 1'b0;
    req_c     = 1'b0;
    addr_c    = pc;
    ld_c      = 1'b0;
    inst_c    = NOP_INST;
    next_c    = '0;
    flush_c   = redirect;
    if (redirect) pc_nxt = align_pc(redirect_pc);
    unique case (state)
      ST_REQ: begin
        req_c = 1'b1;
        if (redirect) begin
          if (!imem_rvalid) begin
            kill_nxt  = pc;
            state_nxt = ST_KILL;
          end
        end else if (imem_rvalid) begin
          if (pc_stall) begin
            hold_ld   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ld_c   = 1'b1;
            inst_c = imem_rdata;
            next_c = pc_inc;
            pc_nxt = pc_inc;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          hold_clr  = 1'b1;
          state_nxt = ST_REQ;
        end else if (!pc_stall) begin
          ld_c      = 1'b1;
          inst_c    = hold_inst;
          next_c    = pc_inc;
          pc_nxt    = pc_inc;
          state_nxt = ST_REQ;
        end
      end
      ST_KILL: begin
        // Stale request finishes at its original address; its data is dropped.
        req_c  = 1'b1;
        addr_c = kill_addr;
        if (imem_rvalid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // Reset values are forced combinationally so they hold regardless of inputs.
  assign imem_req    = rst & req_c;
  assign imem_addr   = rst ? addr_c : RESET_PC;
  assign ifid_ld     = rst & ld_c;
  assign flush       = rst & flush_c;
  assign inst        = rst ? inst_c : NOP_INST;
  assign nextaddress = rst ? next_c : '0;

endmodule
